// File: rtl/echo_delay_pkg.sv
// Shared audio definitions for the effect chain: sample format, control field
// layout, FSM encoding and the common 18-bit saturation helper.
package echo_delay_pkg;

  localparam int AUDIO_W = 18;

  localparam logic signed [AUDIO_W-1:0] SAT_MAX = 18'sd131071;
  localparam logic signed [AUDIO_W-1:0] SAT_MIN = 18'sh20000;  // -131072

  localparam int DLY_MSB  = 7;
  localparam int DLY_LSB  = 4;
  localparam int GAIN_MSB = 3;
  localparam int GAIN_LSB = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Overflow of a 19-bit sum shows up as disagreement of its top two bits.
  function automatic logic signed [AUDIO_W-1:0] sat18(input logic signed [AUDIO_W:0] v);
    if (v[AUDIO_W] != v[AUDIO_W-1])
      return v[AUDIO_W] ? SAT_MIN : SAT_MAX;
    return v[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Echo history buffer: one write port, one synchronous read port, block-RAM style.
module echo_ram
  import echo_delay_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                      clock,
  input  logic                      i_we,
  input  logic [ADDR_W-1:0]         i_waddr,
  input  logic signed [AUDIO_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]         i_raddr,
  output logic signed [AUDIO_W-1:0] o_rdata
);

  logic signed [AUDIO_W-1:0] r_mem [2**ADDR_W];
  logic signed [AUDIO_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_delay.sv
// Feedback echo: mixes each sample with a gain-scaled copy from S*DELAY_STEP
// samples ago and writes the mix back, so echoes decay geometrically.
module echo_delay
  import echo_delay_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DELAY_STEP = 256
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [AUDIO_W-1:0] audio_in,
  input  logic                      ready,
  input  logic [7:0]                controls,
  output logic signed [AUDIO_W-1:0] audio_out,
  output logic                      ready_out,
  output logic                      busy
);

  function automatic logic signed [AUDIO_W-1:0] scale_gain(
    input logic signed [AUDIO_W-1:0] r,
    input logic [3:0]                g
  );
    logic signed [AUDIO_W+4:0] prod;
    prod = r * $signed({1'b0, g});
    prod = prod >>> 4;
    return prod[AUDIO_W-1:0];
  endfunction

  state_t                    r_state, w_state_nxt;
  logic [ADDR_W-1:0]         r_clr_cnt;
  logic [ADDR_W-1:0]         r_wr_ptr;

  logic                      w_accept;
  logic [3:0]                w_dly_sel;
  logic [ADDR_W-1:0]         w_dly;
  logic [ADDR_W-1:0]         w_raddr;
  logic signed [AUDIO_W-1:0] w_rdata;
  logic signed [AUDIO_W-1:0] w_p;
  logic signed [AUDIO_W:0]   w_sum;
  logic signed [AUDIO_W-1:0] w_y;

  logic                      w_ram_we;
  logic [ADDR_W-1:0]         w_ram_waddr;
  logic signed [AUDIO_W-1:0] w_ram_wdata;

  logic signed [AUDIO_W-1:0] r_x_p0;
  logic [3:0]                r_gain_p0;
  logic                      r_byp_p0;
  logic [ADDR_W-1:0]         r_n_p0;
  logic                      r_vld_p0;

  logic signed [AUDIO_W-1:0] r_x_p1;
  logic signed [AUDIO_W-1:0] r_p_p1;
  logic [ADDR_W-1:0]         r_n_p1;
  logic                      r_vld_p1;

  assign w_accept  = ready && (r_state == ST_RUN);
  assign w_dly_sel = controls[DLY_MSB:DLY_LSB];
  // Delays that are a whole multiple of the depth wrap to zero and act as bypass.
  assign w_dly     = ADDR_W'(int'(w_dly_sel) * DELAY_STEP);
  assign w_raddr   = r_wr_ptr - w_dly;

  echo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clock   (clock),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_n_p1;
    w_ram_wdata = w_y;
    case (r_state)
      ST_CLEAR: begin
        busy        = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_waddr = r_clr_cnt;
        w_ram_wdata = '0;
        if (r_clr_cnt == '1)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_ram_we = r_vld_p1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_wr_ptr  <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      ready_out <= 1'b0;
      audio_out <= '0;
    end else begin
      r_state  <= w_state_nxt;
      if (r_state == ST_CLEAR)
        r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_accept)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      r_vld_p0  <= w_accept;
      r_vld_p1  <= r_vld_p0;
      ready_out <= r_vld_p1;
      if (r_vld_p1)
        audio_out <= w_y;
    end
  end

  // Stage 0: capture sample, gain and write index; RAM read issued this edge.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_x_p0    <= audio_in;
      r_gain_p0 <= controls[GAIN_MSB:GAIN_LSB];
      r_byp_p0  <= (w_dly == '0);
      r_n_p0    <= r_wr_ptr;
    end
  end

  assign w_p = r_byp_p0 ? '0 : scale_gain(w_rdata, r_gain_p0);

  // Stage 1: delayed sample scaled by G/16.
  always_ff @(posedge clock) begin
    if (r_vld_p0) begin
      r_x_p1 <= r_x_p0;
      r_p_p1 <= w_p;
      r_n_p1 <= r_n_p0;
    end
  end

  // Stage 2: saturating mix, registered out and written back at index n.
  assign w_sum = {r_x_p1[AUDIO_W-1], r_x_p1} + {r_p_p1[AUDIO_W-1], r_p_p1};
  assign w_y   = sat18(w_sum);

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay: reset/clear timing, bypass, impulse echo,
// saturation, back-to-back streaming and reset in mid-stream.
module tb_echo_delay;

  localparam int ADDR_W     = 12;
  localparam int DELAY_STEP = 256;
  localparam int DEPTH      = 1 << ADDR_W;

  logic               clock;
  logic               reset;
  logic signed [17:0] audio_in;
  logic               ready;
  logic [7:0]         controls;
  logic signed [17:0] audio_out;
  logic               ready_out;
  logic               busy;

  echo_delay #(.ADDR_W(ADDR_W), .DELAY_STEP(DELAY_STEP)) dut (
    .clock     (clock),
    .reset     (reset),
    .audio_in  (audio_in),
    .ready     (ready),
    .controls  (controls),
    .audio_out (audio_out),
    .ready_out (ready_out),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int mdl_mem [DEPTH];
  int mdl_ptr = 0;
  int got [1024];
  int obs_idx = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference: y = clamp(x + floor(r*G/16)), r = history at n - (S*STEP mod depth).
  function automatic int model_step(input int x, input int s, input int g);
    int d, p, y;
    d = (s * DELAY_STEP) % DEPTH;
    p = 0;
    if (d != 0)
      p = (mdl_mem[(mdl_ptr - d + DEPTH) % DEPTH] * g) >>> 4;
    y = x + p;
    if (y > 131071) y = 131071;
    if (y < -131072) y = -131072;
    mdl_mem[mdl_ptr] = y;
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
    return y;
  endfunction

  always @(negedge clock) begin
    if (ready_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ready_out", int'(ready_out), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("audio_out", int'(audio_out), mon_e.val);
        chk("latency_cycle", cyc, mon_e.due);
      end
      if (obs_idx < 1024) got[obs_idx] = int'(audio_out);
      obs_idx++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int x, input int s, input int g);
    exp_t t;
    audio_in = 18'(x);
    controls = 8'((s << 4) | g);
    ready    = 1'b1;
    t.val = model_step(x, s, g);
    t.due = cyc + 3;
    exp_q.push_back(t);
    step();
    ready = 1'b0;
  endtask

  // Reset, drop in-flight expectations, then time the buffer clear while
  // poking ready pulses that must be ignored.
  task automatic do_reset();
    int n;
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clock);
    #1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 0;
    mdl_ptr = 0;
    obs_idx = 0;
    step();
    step();
    @(negedge clock);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready_out", int'(ready_out), 0);
    chk("rst_audio_out", int'(audio_out), 0);
    step();
    reset = 1'b0;
    n = 0;
    @(negedge clock);
    while (busy === 1'b1 && n < 5000) begin
      n++;
      ready    = (n == 10 || n == 11 || n == 2000);
      audio_in = 18'sd12345;
      controls = 8'h18;
      if (n == 3000) chk("clear_audio_out", int'(audio_out), 0);
      @(negedge clock);
    end
    ready = 1'b0;
    chk("busy_len", n, DEPTH);
    step();
  endtask

  task automatic impulse_run(input int base);
    send(65536, 1, 8);
    for (int i = 1; i < 600; i++) send(0, 1, 8);
    idle(6);
    chk("imp_s0", got[base], 65536);
    chk("imp_s1", got[base + 1], 0);
    chk("imp_s255", got[base + 255], 0);
    chk("imp_s256", got[base + 256], 32768);
    chk("imp_s257", got[base + 257], 0);
    chk("imp_s512", got[base + 512], 16384);
    chk("imp_s599", got[base + 599], 0);
    chk("imp_pending", exp_q.size(), 0);
  endtask

  initial begin
    reset    = 1'b1;
    ready    = 1'b0;
    audio_in = '0;
    controls = '0;

    do_reset();

    send(1000, 0, 0);
    send(-5000, 0, 0);
    idle(6);
    chk("byp_s0", got[0], 1000);
    chk("byp_s1", got[1], -5000);
    chk("byp_hold", int'(audio_out), -5000);
    chk("byp_count", obs_idx, 2);

    do_reset();
    impulse_run(0);

    do_reset();
    for (int i = 0; i < 300; i++) send(131071, 1, 15);
    idle(6);
    chk("satp_s0", got[0], 131071);
    chk("satp_s255", got[255], 131071);
    chk("satp_s256", got[256], 131071);
    chk("satp_s299", got[299], 131071);

    do_reset();
    for (int i = 0; i < 300; i++) send(-131072, 1, 15);
    idle(6);
    chk("satn_s0", got[0], -131072);
    chk("satn_s256", got[256], -131072);

    do_reset();
    for (int i = 0; i < 600; i++) send(((i * 7919) % 262144) - 131072, 2, 4);
    idle(6);
    chk("b2b_count", obs_idx, 600);
    chk("b2b_pending", exp_q.size(), 0);

    do_reset();
    for (int i = 0; i < 300; i++) send(20000 + i, 1, 8);
    do_reset();
    chk("mid_no_flush_out", obs_idx, 0);
    // Delay 3840 reaches addresses 256..259, which held pre-reset data.
    for (int i = 0; i < 4; i++) send(0, 15, 15);
    impulse_run(4);
    chk("mid_s0", got[0], 0);
    chk("mid_s3", got[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
